multi_channel_binarizer: RTL
============================

# multi_channel_binarizer

Parametrised, frame-synchronous binarization stage for the ISP colour path. Takes NCH packed colour channels (typically Y/Cb/Cr from the colour-space converter), applies a per-channel band threshold with optional hue-style wrap-around, combines channels with AND/OR logic and optional inversion, and emits a full-scale binary pixel stream. It also accumulates per-frame foreground statistics (pixel count and bounding box) for downstream target tracking.

## Interface
Parameters:
- DW, 8, bits per channel
- NCH, 3, number of packed input channels
- XW, 12, column coordinate width
- YW, 12, row coordinate width
- CW, 24, foreground-count width

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- cfg_ch_en  in  NCH  channel enable mask
- cfg_lo  in  NCH*DW  per-channel lower bound; channel i is at [i*DW +: DW]
- cfg_hi  in  NCH*DW  per-channel upper bound; same packing as cfg_lo
- cfg_mode  in  1  0 = AND of enabled channels, 1 = OR
- cfg_invert  in  1  invert the final foreground decision
- i_vsync  in  1  frame sync, active high during frame
- i_href  in  1  line valid
- i_clken  in  1  pixel valid
- i_data  in  NCH*DW  packed pixel, channel i at [i*DW +: DW]
- o_vsync, o_href, o_clken  out  1 each  delayed syncs
- o_data  out  DW  all-ones = foreground, zero = background
- o_fg_count  out  CW  foreground pixels in last frame
- o_x_min, o_x_max  out  XW  bounding box columns
- o_y_min, o_y_max  out  YW  bounding box rows
- o_bbox_valid  out  1  last frame contained at least one foreground pixel
- o_stat_valid  out  1  one-cycle pulse when the statistics outputs update

## Operation
- Shadow config: all cfg_* inputs are latched into shadow registers on the cycle a rising edge of i_vsync is detected (i_vsync=1, previous=0). Changes mid-frame have no effect until the next frame. Reset value of every shadow register is 0, so the output is background until the first frame.
- Channel match for d=channel value, lo, hi:
  - if lo<=hi: match = lo<=d<=hi
  - if lo>hi (wrap band): match = d>=lo or d<=hi
  - all comparisons are unsigned
- Combine:
  - In AND mode, disabled channels count as 1. In OR mode, they count as 0.
  - If no channel is enabled, the combined match is 0, regardless of mode.
- Decision: fg = combined ^ invert. o_data = fg ? {DW{1'b1}} : 0. This applies only when the stage-2 clken is high; otherwise o_data = 0.
- Coordinates:
  - x counter: increments on each i_clken while i_href=1. Clears when i_href falls.
  - y counter: increments on each i_href falling edge.
  - Both counters clear on the i_vsync rising edge.
  - A pixel's coordinate is the counter value before increment.
  - Both counters saturate at all-ones.
- Accumulators (the working set, cleared at frame start):
  - count: incremented per fg pixel; saturates at 2^CW-1.
  - bbox: min/max updated per fg pixel.
  - any: a flag set by the first fg pixel.
- Frame end is the falling edge of the stage-2 vsync. The cycle after it:
  - the accumulators are copied to the o_fg_count/o_x_*/o_y_* registers;
  - o_bbox_valid is set to any;
  - o_stat_valid pulses for 1 cycle.
  - If any=0, all bbox outputs are 0.
- Statistics outputs hold until the next frame end.
- A frame that starts but is cut short by reset produces no stat pulse.

## Timing
- Reset (asynchronous): all outputs, pipeline registers, counters, accumulators and shadow config are 0.
- Pipeline:
  - Stage 1 registers the per-channel matches and delayed syncs.
  - Stage 2 registers the combine/invert result and updates the accumulators.
  - o_vsync/o_href/o_clken/o_data are i_* delayed by exactly 2 cycles, mutually aligned.
- Throughput: one pixel per cycle, with no back-pressure. Pixels with i_clken=0 are ignored for data and statistics.
- Config latch: a pixel in the same cycle as the vsync rising edge uses the new config. This is required so the first pixel may coincide with vsync.
- Stats: if i_vsync falls at cycle k, o_vsync falls at k+2 and o_stat_valid is high at cycle k+3 only.
- Simultaneous events:
  - If a vsync rising edge arrives the same cycle as the previous frame's stat pulse, copy first, then clear.
  - i.e. the stat registers take the old accumulator values.
- Reset mid-frame: everything returns to reset state immediately. The next rising edge of i_vsync starts a clean frame.

## Test plan
- Reset then frame 4x2, ch0 band lo=50 hi=100, AND, only ch0 enabled, Y values {40,50,100,101} per line -> o_data {00,FF,FF,00} 2 cycles after each pixel; o_fg_count=4, x 1..2, y 0..1, o_stat_valid at i_vsync fall+3.
- Wrap band ch1 lo=200 hi=20, values {10,100,210,20} -> fg {1,0,1,1}.
- OR mode, ch0 [0,10], ch2 [240,255], both enabled, pixel (5,128,250) and (50,128,100) -> FF then 00; same with cfg_invert=1 -> 00 then FF.
- Change cfg_lo mid-frame -> current frame output unchanged; new bounds take effect on the first pixel of the next frame.
- Frame with no fg pixels -> o_fg_count=0, o_bbox_valid=0, all bbox=0, o_stat_valid still pulses; cfg_ch_en=0 in AND mode -> all background.
- Assert rst mid-frame -> all outputs 0 immediately, no stat pulse for the cut frame; the following full frame reports correct stats.

Source files
------------

// File: rtl/multi_channel_binarizer.sv
// rtl/multi_channel_binarizer.sv - per-channel band threshold binarizer with frame foreground statistics
// Two-stage pipeline: stage 1 registers channel matches, stage 2 combines and accumulates stats.
module multi_channel_binarizer #(
  parameter int DW  = 8,
  parameter int NCH = 3,
  parameter int XW  = 12,
  parameter int YW  = 12,
  parameter int CW  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    cfg_ch_en,
  input  logic [NCH*DW-1:0] cfg_lo,
  input  logic [NCH*DW-1:0] cfg_hi,
  input  logic              cfg_mode,
  input  logic              cfg_invert,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic              i_clken,
  input  logic [NCH*DW-1:0] i_data,
  output logic              o_vsync,
  output logic              o_href,
  output logic              o_clken,
  output logic [DW-1:0]     o_data,
  output logic [CW-1:0]     o_fg_count,
  output logic [XW-1:0]     o_x_min,
  output logic [XW-1:0]     o_x_max,
  output logic [YW-1:0]     o_y_min,
  output logic [YW-1:0]     o_y_max,
  output logic              o_bbox_valid,
  output logic              o_stat_valid
);

  logic              vs_prev_q, href_prev_q, vs_rise, href_fall;
  logic [NCH-1:0]    sh_en_q, cur_en;
  logic [NCH*DW-1:0] sh_lo_q, sh_hi_q, cur_lo, cur_hi;
  logic              sh_mode_q, sh_inv_q, cur_mode, cur_inv;

  assign vs_rise   = i_vsync & ~vs_prev_q;
  assign href_fall = ~i_href & href_prev_q;

  // The frame-start cycle already sees the new config so the first pixel may coincide with vsync.
  assign cur_en   = vs_rise ? cfg_ch_en  : sh_en_q;
  assign cur_lo   = vs_rise ? cfg_lo     : sh_lo_q;
  assign cur_hi   = vs_rise ? cfg_hi     : sh_hi_q;
  assign cur_mode = vs_rise ? cfg_mode   : sh_mode_q;
  assign cur_inv  = vs_rise ? cfg_invert : sh_inv_q;

  logic [NCH-1:0] match_d;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DW-1:0] d, lo, hi;
    assign d  = i_data[g*DW +: DW];
    assign lo = cur_lo[g*DW +: DW];
    assign hi = cur_hi[g*DW +: DW];
    assign match_d[g] = (lo <= hi) ? ((d >= lo) && (d <= hi)) : ((d >= lo) || (d <= hi));
  end

  logic [XW-1:0] x_q, x_d, x_base;
  logic [YW-1:0] y_q, y_d, y_base;

  always_comb begin
    x_base = vs_rise ? '0 : x_q;
    y_base = vs_rise ? '0 : y_q;
    x_d    = x_base;
    y_d    = y_base;
    if (href_fall) begin
      x_d = '0;
      if (!vs_rise && (y_q != '1)) y_d = y_q + YW'(1);
    end else if (i_href && i_clken && (x_base != '1)) begin
      x_d = x_base + XW'(1);
    end
  end

  logic           s1_vs_q, s1_href_q, s1_clken_q, s1_mode_q, s1_inv_q;
  logic [NCH-1:0] s1_match_q, s1_en_q;
  logic [XW-1:0]  s1_x_q;
  logic [YW-1:0]  s1_y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      sh_en_q     <= '0;
      sh_lo_q     <= '0;
      sh_hi_q     <= '0;
      sh_mode_q   <= 1'b0;
      sh_inv_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      s1_vs_q     <= 1'b0;
      s1_href_q   <= 1'b0;
      s1_clken_q  <= 1'b0;
      s1_match_q  <= '0;
      s1_en_q     <= '0;
      s1_mode_q   <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
    end else begin
      vs_prev_q   <= i_vsync;
      href_prev_q <= i_href;
      if (vs_rise) begin
        sh_en_q   <= cfg_ch_en;
        sh_lo_q   <= cfg_lo;
        sh_hi_q   <= cfg_hi;
        sh_mode_q <= cfg_mode;
        sh_inv_q  <= cfg_invert;
      end
      x_q         <= x_d;
      y_q         <= y_d;
      s1_vs_q     <= i_vsync;
      s1_href_q   <= i_href;
      s1_clken_q  <= i_clken;
      s1_match_q  <= match_d;
      s1_en_q     <= cur_en;
      s1_mode_q   <= cur_mode;
      s1_inv_q    <= cur_inv;
      s1_x_q      <= x_base;
      s1_y_q      <= y_base;
    end
  end

  logic and_all, or_any, fg, hit;

  always_comb begin
    and_all = 1'b1;
    or_any  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (s1_en_q[i]) begin
        and_all = and_all & s1_match_q[i];
        or_any  = or_any | s1_match_q[i];
      end
    end
    fg = ((|s1_en_q) & (s1_mode_q ? or_any : and_all)) ^ s1_inv_q;
  end

  logic          vs2_q, vs2_prev_q, href2_q, clken2_q, stat_valid_q, bbox_valid_q;
  logic [DW-1:0] data2_q;
  logic          frame_start, frame_end;
  logic [CW-1:0] cnt_q, cnt_d, fg_count_q;
  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, x_min_q, x_max_q;
  logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d, y_min_q, y_max_q;
  logic          any_q, any_d;

  // Frame start is seen at stage 1 so the clear lands on the same edge as the first pixel's update.
  assign frame_start = s1_vs_q & ~vs2_q;
  assign frame_end   = ~vs2_q & vs2_prev_q;
  assign hit         = s1_clken_q & fg;

  always_comb begin
    cnt_d  = frame_start ? '0   : cnt_q;
    xmin_d = frame_start ? '0   : xmin_q;
    xmax_d = frame_start ? '0   : xmax_q;
    ymin_d = frame_start ? '0   : ymin_q;
    ymax_d = frame_start ? '0   : ymax_q;
    any_d  = frame_start ? 1'b0 : any_q;
    if (hit) begin
      if (cnt_d != '1) cnt_d = cnt_d + CW'(1);
      if (!any_d || (s1_x_q < xmin_d)) xmin_d = s1_x_q;
      if (!any_d || (s1_x_q > xmax_d)) xmax_d = s1_x_q;
      if (!any_d || (s1_y_q < ymin_d)) ymin_d = s1_y_q;
      if (!any_d || (s1_y_q > ymax_d)) ymax_d = s1_y_q;
      any_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs2_q        <= 1'b0;
      vs2_prev_q   <= 1'b0;
      href2_q      <= 1'b0;
      clken2_q     <= 1'b0;
      data2_q      <= '0;
      cnt_q        <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      any_q        <= 1'b0;
      fg_count_q   <= '0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      bbox_valid_q <= 1'b0;
      stat_valid_q <= 1'b0;
    end else begin
      vs2_q        <= s1_vs_q;
      vs2_prev_q   <= vs2_q;
      href2_q      <= s1_href_q;
      clken2_q     <= s1_clken_q;
      data2_q      <= hit ? '1 : '0;
      cnt_q        <= cnt_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      any_q        <= any_d;
      stat_valid_q <= frame_end;
      // Copy reads the pre-clear accumulator values even when a new frame starts this edge.
      if (frame_end) begin
        fg_count_q   <= cnt_q;
        x_min_q      <= any_q ? xmin_q : '0;
        x_max_q      <= any_q ? xmax_q : '0;
        y_min_q      <= any_q ? ymin_q : '0;
        y_max_q      <= any_q ? ymax_q : '0;
        bbox_valid_q <= any_q;
      end
    end
  end

  assign o_vsync      = vs2_q;
  assign o_href       = href2_q;
  assign o_clken      = clken2_q;
  assign o_data       = data2_q;
  assign o_fg_count   = fg_count_q;
  assign o_x_min      = x_min_q;
  assign o_x_max      = x_max_q;
  assign o_y_min      = y_min_q;
  assign o_y_max      = y_max_q;
  assign o_bbox_valid = bbox_valid_q;
  assign o_stat_valid = stat_valid_q;

endmodule
